cmos_gate_seq_checker: RTL and testbench
========================================

// Module: cmos_gate_seq_checker
// PURPOSE
// - Sequencer/checker for one transistor-level CMOS logic cell (e.g. the 2-input CMOS AND cell).
// - On start, walks every input combination onto the cell's inputs and waits a programmable settle time.
// - Samples the cell output, compares it to an expected truth table, then reports errors and pass/fail.
// - Sits between a test controller (or bench) and the switch-level gate under test.
// PARAMETERS
// - N_IN    2        number of cell inputs (1..4); 2**N_IN vectors applied
// - SETTLE  3        cycles each vector is held before y_in is sampled (>=1)
// - TRUTH   4'b1000  expected output; bit k = expected y for vector k (default = AND)
// PORTS
// - clk         in   1        single clock, all state on rising edge
// - rst_n       in   1        asynchronous, active-low reset
// - start       in   1        pulse; begins a sweep when idle, ignored while busy
// - a_out       out  N_IN     registered drive to cell inputs; a_out[0] -> cell input a
// - y_in        in   1        cell output under test
// - busy        out  1        high from the cycle after start until done
// - done        out  1        one-cycle pulse at end of sweep
// - pass        out  1        1 when last sweep had zero mismatches; held until next start
// - err_cnt     out  N_IN+1   mismatch count of current/last sweep; never wraps
// - fail_valid  out  1        one-cycle pulse on each mismatch
// - fail_vec    out  N_IN     vector of the most recent mismatch; held
// BEHAVIOUR
// - Reset (async assert, synchronous release): state IDLE; a_out=0, busy=0, done=0, pass=0,
//   err_cnt=0, fail_valid=0, fail_vec=0, settle counter=0. Reset mid-sweep aborts with no done pulse.
// - FSM states: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
// - IDLE: on start=1: a_out<=0, cnt<=SETTLE, err_cnt<=0, pass<=0, fail_vec<=0, go to SETTLE.
// - SETTLE: busy=1; cnt decrements each cycle; when cnt==1, go to SAMPLE (exactly SETTLE cycles in state).
// - SAMPLE (1 cycle): mismatch = (y_in !== TRUTH[a_out]); X/Z on y_in counts as mismatch.
//   - On mismatch: err_cnt++, fail_vec<=a_out, fail_valid=1 for that cycle.
//   - If a_out == 2**N_IN-1, go to DONE; else a_out++, cnt<=SETTLE, go to SETTLE.
//   - a_out holds its value in SAMPLE; it changes only on the SAMPLE->SETTLE edge.
// - DONE (1 cycle): done=1, busy=0, pass<=(err_cnt==0 after final compare); go to IDLE.
//   - a_out stays at the last vector until the next start.
// - Latency: the done pulse occurs 2**N_IN*(SETTLE+1)+1 rising edges after the start edge
//   (17 for the defaults).
// - start while busy or in DONE: ignored, no restart.
// - start in the same cycle as the DONE state returning to IDLE: ignored; the next start in IDLE is accepted.
// - err_cnt width N_IN+1 holds the maximum 2**N_IN errors; no saturation logic needed.
// CONFIGURATION
// - Macro CMOS_SEQ_STOP_ON_FAIL_EN:
//   - Defined: the first mismatch ends the sweep. SAMPLE goes directly to DONE (err_cnt=1, pass=0,
//     fail_vec = failing vector), and a_out holds the failing vector.
//   - Undefined (default): full sweep always runs and every mismatch is counted.
// STRUCTURE
// - Package cmos_seq_pkg:
//   - state enum (IDLE, SETTLE, SAMPLE, DONE);
//   - truth-table constants TT_AND2=4'b1000, TT_OR2=4'b1110, TT_NAND2=4'b0111, TT_NOR2=4'b0001,
//     TT_XOR2=4'b0110, TT_INV=2'b01.
// - Sub-module cmos_settle_timer: loadable down-counter (load, load_val, expire); instantiated once.
// - FSM, vector register, compare logic and status registers live in the top module.
// TESTING
// - Drive the 2-input CMOS AND cell, TRUTH=TT_AND2, SETTLE=3, pulse start.
//   -> a_out steps 00,01,10,11, each held 4 cycles; done at edge 17; pass=1, err_cnt=0, no fail_valid.
// - Same cell, but TRUTH=TT_NAND2.
//   -> fail_valid pulses 4 times; err_cnt=4; pass=0; fail_vec=2'b11.
// - Force y_in=1 during vector 2'b01 only, TRUTH=TT_AND2.
//   -> exactly one fail_valid; err_cnt=1; fail_vec=2'b01; pass=0.
// - Leave y_in=1'bz for the whole sweep.
//   -> err_cnt=4, pass=0 (X/Z counted as mismatch).
// - Pulse start again at edge 5 of a sweep, then assert rst_n=0 at edge 9.
//   -> second start ignored; after reset all outputs are 0, state IDLE, and no done pulse occurs.
//   -> A new start then completes normally in 17 edges.
// - With CMOS_SEQ_STOP_ON_FAIL_EN defined, TRUTH=TT_NAND2.
//   -> done at edge 5; err_cnt=1; fail_vec=2'b00; a_out=2'b00; pass=0.

Source files
------------

// File: rtl/cmos_seq_pkg.sv
// Shared types and constants for the CMOS cell sequencer/checker.
// Holds the sweep FSM state encoding, the common two-input truth tables
// and the per-vector compare helper.
package cmos_seq_pkg;

    // Sweep FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

    // Expected-output tables: bit k is the expected y for input vector k.
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [1:0] TT_INV   = 2'b01;

    // A sampled cell output is wrong unless it is exactly the expected
    // level; an unknown or floating output is a failure.
    function automatic logic vec_mismatch(input logic y, input logic exp_y);
        return (y !== exp_y);
    endfunction

endpackage

// File: rtl/cmos_settle_timer.sv
// Loadable down-counter that times how long each input vector is held
// before the cell output is sampled. expire is high on the last cycle of
// the hold period (count == 1); the counter then rests at zero.
module cmos_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    logic [W-1:0] cnt_r;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= CNT_ZERO;
        end
    end

    assign expire = (cnt_r == CNT_ONE);

endmodule

// File: rtl/cmos_gate_seq_checker.sv
// Sequencer/checker for one CMOS logic cell. A start pulse walks every
// input combination onto a_out, holds each for SETTLE cycles, samples
// y_in for one cycle against TRUTH and accumulates mismatches.
// Optional build macro CMOS_SEQ_STOP_ON_FAIL_EN: when defined, the first
// mismatch ends the sweep and a_out keeps the failing vector.
module cmos_gate_seq_checker
    import cmos_seq_pkg::*;
#(
    parameter int                    N_IN   = 2,
    parameter int                    SETTLE = 3,
    parameter logic [(2**N_IN)-1:0]  TRUTH  = TT_AND2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] a_out,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);

    localparam int                CNT_W     = $clog2(SETTLE + 1);
    localparam int                ERR_W     = N_IN + 1;
    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE);
    localparam logic [N_IN-1:0]   VEC_ZERO  = {N_IN{1'b0}};
    localparam logic [N_IN-1:0]   VEC_ONE   = N_IN'(1);
    localparam logic [N_IN-1:0]   VEC_LAST  = {N_IN{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_ZERO  = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);

    seq_state_e        state_r;
    seq_state_e        state_s;
    logic [N_IN-1:0]   a_out_r;
    logic [ERR_W-1:0]  err_cnt_r;
    logic [N_IN-1:0]   fail_vec_r;
    logic              pass_r;
    logic              busy_r;
    logic              done_r;

    logic              load_s;
    logic              expire_s;
    logic              exp_y_s;
    logic              mismatch_s;
    logic              last_vec_s;
    logic              end_sweep_s;
    logic              fail_valid_s;

    cmos_settle_timer #(
        .W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .load_val (SETTLE_LD),
        .expire   (expire_s)
    );

    assign exp_y_s      = TRUTH[a_out_r];
    assign mismatch_s   = vec_mismatch(y_in, exp_y_s);
    assign last_vec_s   = (a_out_r == VEC_LAST);
    assign fail_valid_s = (state_r == ST_SAMPLE) && mismatch_s;

`ifdef CMOS_SEQ_STOP_ON_FAIL_EN
    // The sweep ends on the last vector or on the first bad sample.
    assign end_sweep_s = last_vec_s || mismatch_s;
`else
    // The sweep always covers every vector.
    assign end_sweep_s = last_vec_s;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and settle-timer reload requests.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SETTLE;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (expire_s) begin
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                if (end_sweep_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SETTLE;
                    load_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Vector register, mismatch bookkeeping and the pass verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out_r    <= VEC_ZERO;
            err_cnt_r  <= ERR_ZERO;
            fail_vec_r <= VEC_ZERO;
            pass_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_out_r    <= VEC_ZERO;
                        err_cnt_r  <= ERR_ZERO;
                        fail_vec_r <= VEC_ZERO;
                        pass_r     <= 1'b0;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch_s) begin
                        err_cnt_r  <= err_cnt_r + ERR_ONE;
                        fail_vec_r <= a_out_r;
                    end
                    if (!end_sweep_s) begin
                        a_out_r <= a_out_r + VEC_ONE;
                    end
                end
                ST_DONE: begin
                    pass_r <= (err_cnt_r == ERR_ZERO);
                end
                default: begin
                    a_out_r <= a_out_r;
                end
            endcase
        end
    end

    // Status flags registered from the upcoming state so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_SETTLE) || (state_s == ST_SAMPLE);
            done_r <= (state_s == ST_DONE);
        end
    end

    assign a_out      = a_out_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_cnt    = err_cnt_r;
    assign fail_vec   = fail_vec_r;
    // Flags the failing sample in the very cycle it is taken.
    assign fail_valid = fail_valid_s;

endmodule

// File: tb/tb_cmos_gate_seq_checker.sv
// Bench for cmos_gate_seq_checker (N_IN=2, SETTLE=3, TRUTH=AND). A
// behavioural cell drives y_in (good AND, NAND, AND stuck-high on 01, or
// unknown). A time-based model predicts every output on every cycle;
// directed sweeps add hand-computed literal expectations. Honours
// CMOS_SEQ_STOP_ON_FAIL_EN when the build defines it.
module tb_cmos_gate_seq_checker;
    import cmos_seq_pkg::*;

    localparam int NV = 4;
    localparam int P  = 4;           // cycles per vector: settle + sample
`ifdef CMOS_SEQ_STOP_ON_FAIL_EN
    localparam int STOP = 1;
`else
    localparam int STOP = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       y_in;
    logic [1:0] a_out;
    logic [1:0] fail_vec;
    logic [2:0] err_cnt;
    logic       busy, done, pass, fail_valid;
    logic [3:0] tt_v = TT_AND2;
    int         mode = 0;
    int         n_vec = 0;
    int         n_bad = 0;

    // Model state: edges since the accepted start edge and sweep results.
    bit m_active = 1'b0;
    bit m_pass   = 1'b0;
    int m_j = 0, m_end = 0, m_err = 0, m_fvec = 0, m_aout = 0;

    always #5 clk = ~clk;

    cmos_gate_seq_checker #(
        .N_IN   (2),
        .SETTLE (3),
        .TRUTH  (TT_AND2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_out      (a_out),
        .y_in       (y_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .fail_valid (fail_valid),
        .fail_vec   (fail_vec)
    );

    // Cell under test, selected by mode.
    always_comb begin
        case (mode)
            0:       y_in = a_out[0] & a_out[1];
            1:       y_in = ~(a_out[0] & a_out[1]);
            2:       y_in = (a_out == 2'b01) ? 1'b1 : (a_out[0] & a_out[1]);
            default: y_in = 1'bx;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: vector k is sampled on edge (k+1)*P after the start edge; the
    // done cycle follows the last sample, pass settles one edge later.
    initial forever begin
        int k;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 1'b0; m_pass = 1'b0;
            m_j = 0; m_end = 0; m_err = 0; m_fvec = 0; m_aout = 0;
        end else if (m_active) begin
            m_j++;
            if (m_j > m_end) begin
                m_pass   = (m_err == 0);
                m_active = 1'b0;
            end else begin
                if (m_j % P == 0) begin
                    k = m_j / P - 1;
                    if (y_in !== tt_v[k]) begin
                        m_err++;
                        m_fvec = k;
                        if (STOP != 0) m_end = m_j;
                    end
                end
                m_aout = (m_j < m_end) ? m_j / P : m_end / P - 1;
            end
        end else if (start) begin
            m_active = 1'b1; m_pass = 1'b0;
            m_j = 0; m_end = NV * P; m_err = 0; m_fvec = 0; m_aout = 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        bit e_busy, e_done, e_fv;
        @(negedge clk);
        e_busy = m_active && (m_j < m_end);
        e_done = m_active && (m_j == m_end);
        e_fv   = e_busy && (m_j % P == P - 1) && (y_in !== tt_v[m_j / P]);
        chk("a_out", a_out, m_aout);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("fail_valid", fail_valid, e_fv);
        chk("err_cnt", err_cnt, m_err);
        chk("fail_vec", fail_vec, m_fvec);
        chk("pass", pass, m_pass);
    end

    // Start a sweep and wait for done; lat = edge that samples done high,
    // counted from the start edge. Returns one cycle after done.
    task automatic run_sweep(input int m, input bit poke, output int lat, output int fv);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        fv  = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            fv += int'(fail_valid);
        end
        if (done !== 1'b1) chk("done_timeout", done, 1);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = lat + 1;
    endtask

    initial begin
        int lat, fv, d;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_a_out", a_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_pass", pass, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Good AND cell, with a start arriving on the DONE->IDLE edge.
        run_sweep(0, 1'b1, lat, fv);
        chk("and_latency", lat, 17);
        chk("and_err", err_cnt, 0);
        chk("and_pass", pass, 1);
        chk("and_fail_pulses", fv, 0);
        chk("and_a_out_held", a_out, 3);
        chk("start_in_done_ignored", busy, 0);
        @(negedge clk);
        chk("start_in_done_still_idle", busy, 0);

        // NAND cell against an AND table: every vector mismatches.
        run_sweep(1, 1'b0, lat, fv);
        chk("nand_latency", lat, STOP ? 5 : 17);
        chk("nand_err", err_cnt, STOP ? 1 : 4);
        chk("nand_fail_vec", fail_vec, STOP ? 0 : 3);
        chk("nand_a_out", a_out, STOP ? 0 : 3);
        chk("nand_pass", pass, 0);
        chk("nand_fail_pulses", fv, STOP ? 1 : 4);

        // Output stuck high on vector 01 only.
        run_sweep(2, 1'b0, lat, fv);
        chk("force01_latency", lat, STOP ? 9 : 17);
        chk("force01_err", err_cnt, 1);
        chk("force01_fail_vec", fail_vec, 1);
        chk("force01_pass", pass, 0);
        chk("force01_fail_pulses", fv, 1);

        // Unknown cell output is never accepted.
        run_sweep(3, 1'b0, lat, fv);
        chk("unknown_pass", pass, 0);
        chk("unknown_err_nonzero", err_cnt != 3'd0, 1);

        // Restart attempt mid-sweep, then abort with reset.
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_ignored_a_out", a_out, 1);
        chk("restart_ignored_busy", busy, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_a_out", a_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_err", err_cnt, 0);
        chk("abort_fail_valid", fail_valid, 0);
        chk("abort_fail_vec", fail_vec, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        d = 0;
        repeat (20) begin
            @(negedge clk);
            d += int'(done);
        end
        chk("abort_no_done", d, 0);

        run_sweep(0, 1'b0, lat, fv);
        chk("post_abort_latency", lat, 17);
        chk("post_abort_pass", pass, 1);
        chk("post_abort_err", err_cnt, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
